// File: rtl/restoring_divider4.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Each trial subtraction is a ripple add of the one's-complement divisor with carry-in 1.
module restoring_divider4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic             accept;
    logic             unused_r_msb;

    // Chain of 1-bit full-adder cells; returns {carry_out, sum}.
    function automatic logic [WIDTH+1:0] ripple_add(input logic [WIDTH:0] a,
                                                    input logic [WIDTH:0] b,
                                                    input logic       cin);
        logic [WIDTH:0] s;
        logic           c;
        c = cin;
        s = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, s};
    endfunction

    // R stays below D, so its top bit is always zero and drops out of the shift.
    assign unused_r_msb = r_q[WIDTH];
    assign rs           = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign {no_borrow, trial} = ripple_add(rs, ~{1'b0, d_q}, 1'b1);

    assign accept = start && (state_q != S_RUN);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        r_d     = '0;
                        q_d     = dividend;
                        d_d     = divisor;
                        cnt_d   = CW'(WIDTH);
                        dbz_d   = 1'b0;
                    end
                end
            end
            S_RUN: begin
                r_d   = no_borrow ? trial : rs;
                q_d   = {q_q[WIDTH-2:0], no_borrow};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    quot_d  = q_d;
                    rem_d   = r_d[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
